// File: rtl/seg_display_ctrl.sv
// Multi-digit seven-segment display controller: holds a loaded value, decodes each
// nibble to active-low segments with optional leading-zero blanking, blinking and forced blank.
module seg_display_ctrl #(
    parameter int DIGITS      = 4,
    parameter int HEX_MODE    = 1,
    parameter int LZ_SUPPRESS = 1,
    parameter int BLINK_DIV   = 25_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  blink_en,
    input  logic                  blank,
    output logic [7*DIGITS-1:0]   hex_out
);

    localparam int            CW      = $clog2(BLINK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [6:0]    SEG_OFF = 7'h7F;

    // Active-high segment pattern for one nibble; bit0 = a .. bit6 = g.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h3F;
            4'h1:    pat = 7'h06;
            4'h2:    pat = 7'h5B;
            4'h3:    pat = 7'h4F;
            4'h4:    pat = 7'h66;
            4'h5:    pat = 7'h6D;
            4'h6:    pat = 7'h7D;
            4'h7:    pat = 7'h07;
            4'h8:    pat = 7'h7F;
            4'h9:    pat = 7'h67;
            4'hA:    pat = (HEX_MODE != 0) ? 7'h77 : 7'h00;
            4'hB:    pat = (HEX_MODE != 0) ? 7'h7C : 7'h00;
            4'hC:    pat = (HEX_MODE != 0) ? 7'h39 : 7'h00;
            4'hD:    pat = (HEX_MODE != 0) ? 7'h5E : 7'h00;
            4'hE:    pat = (HEX_MODE != 0) ? 7'h79 : 7'h00;
            4'hF:    pat = (HEX_MODE != 0) ? 7'h71 : 7'h00;
            default: pat = 7'h00;
        endcase
        return pat;
    endfunction

    logic [4*DIGITS-1:0] value_r;
    logic [CW-1:0]       cnt_r;
    logic                phase_r;
    logic [DIGITS-1:0]   suppress_s;
    logic                leading_s;
    logic                all_off_s;
    logic [7*DIGITS-1:0] next_hex_s;

    // Leading-zero mask: zeros above the first nonzero digit go dark, digit 0 never does.
    always_comb begin
        leading_s  = 1'b1;
        suppress_s = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if ((LZ_SUPPRESS != 0) && leading_s && (value_r[4*i +: 4] == 4'h0) && (i != 0)) begin
                suppress_s[i] = 1'b1;
            end else begin
                suppress_s[i] = 1'b0;
            end
            if (value_r[4*i +: 4] != 4'h0) begin
                leading_s = 1'b0;
            end else begin
                leading_s = leading_s;
            end
        end
    end

    // Next output word: forced blank beats blink-off phase, which beats normal decode.
    always_comb begin
        all_off_s  = blank | (blink_en & phase_r);
        next_hex_s = {DIGITS{SEG_OFF}};
        for (int i = 0; i < DIGITS; i++) begin
            if (all_off_s || suppress_s[i]) begin
                next_hex_s[7*i +: 7] = SEG_OFF;
            end else begin
                next_hex_s[7*i +: 7] = ~seg_decode(value_r[4*i +: 4]);
            end
        end
    end

    // Display register, blink timer and registered segment outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_r <= '0;
            cnt_r   <= '0;
            phase_r <= 1'b0;
            hex_out <= {DIGITS{SEG_OFF}};
        end else begin
            if (load) begin
                value_r <= value;
            end else begin
                value_r <= value_r;
            end
            // Disabling blink parks the timer so re-enabling starts with a full visible half-period.
            if (!blink_en) begin
                cnt_r   <= '0;
                phase_r <= 1'b0;
            end else if (cnt_r == CNT_MAX) begin
                cnt_r   <= '0;
                phase_r <= ~phase_r;
            end else begin
                cnt_r   <= cnt_r + CNT_ONE;
                phase_r <= phase_r;
            end
            hex_out <= next_hex_s;
        end
    end

endmodule
